// File: rtl/score_log_pkg.sv
// Shared types for the score log sequencer: FSM state encoding and default widths.
package score_log_pkg;
  localparam int DEF_AW = 5;
  localparam int DEF_SW = 10;

  typedef enum logic [2:0] {IDLE, WRITE, SCAN, DRAIN, PUBLISH} state_t;
  typedef logic [DEF_SW-1:0] score_t;
  typedef logic [DEF_AW-1:0] ptr_t;
endpackage

// File: rtl/score_log_ctrl_top3_insert.sv
// Combinational insertion of one value into a descending top-3 triple (index 0 = highest).
module top3_insert #(
  parameter int SW = 10
) (
  input  logic [SW-1:0]       v,
  input  logic [2:0][SW-1:0]  s_in,
  output logic [2:0][SW-1:0]  s_out
);
  logic [2:0] gt;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cmp
      assign gt[gi] = (v > s_in[gi]);
    end
  endgenerate

  // Strict compare: an equal value lands below the existing one.
  always_comb begin
    s_out = s_in;
    if (gt[0])      s_out = {s_in[1], s_in[0], v};
    else if (gt[1]) s_out = {s_in[1], v, s_in[0]};
    else if (gt[2]) s_out = {v, s_in[1], s_in[0]};
  end
endmodule

// File: rtl/score_log_ctrl.sv
// Score log sequencer: circular score writes, serial rescan, registered top-3 publish.
// Defining SCORE_LOG_CLEAR_EN adds a 'clear' input that wipes history while idle.
module score_log_ctrl
  import score_log_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int SW = DEF_SW
) (
  input  logic          clock,
  input  logic          reset_n,
`ifdef SCORE_LOG_CLEAR_EN
  input  logic          clear,
`endif
  input  logic          game_over,
  input  logic [SW-1:0] score,
  output logic [AW-1:0] mem_addr,
  output logic [SW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [SW-1:0] mem_rdata,
  output logic [SW-1:0] top0,
  output logic [SW-1:0] top1,
  output logic [SW-1:0] top2,
  output logic          top_valid,
  output logic          busy,
  output logic [AW:0]   entries,
  output logic          dropped
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  state_t             state_reg, state_next;
  logic [AW-1:0]      wr_ptr_reg, rd_idx_reg;
  logic [AW:0]        entries_reg;
  logic [SW-1:0]      lat_score_reg, pend_score_reg;
  logic               pending_reg, dropped_reg, top_valid_reg;
  logic [2:0][SW-1:0] scratch_reg, top_reg, scratch_ins;
  logic               clear_req, scan_last;

`ifdef SCORE_LOG_CLEAR_EN
  assign clear_req = clear;
`else
  assign clear_req = 1'b0;
`endif

  assign scan_last = ({1'b0, rd_idx_reg} == entries_reg - (AW+1)'(1));

  top3_insert #(.SW(SW)) u_insert (
    .v     (mem_rdata),
    .s_in  (scratch_reg),
    .s_out (scratch_ins)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE:    if (!clear_req && (game_over || pending_reg)) state_next = WRITE;
      WRITE: begin
        mem_wren   = 1'b1;
        mem_addr   = wr_ptr_reg;
        mem_wdata  = lat_score_reg;
        state_next = SCAN;
      end
      SCAN: begin
        mem_addr = rd_idx_reg;
        if (scan_last) state_next = DRAIN;
      end
      DRAIN:   state_next = PUBLISH;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_idx_reg     <= '0;
      entries_reg    <= '0;
      lat_score_reg  <= '0;
      pend_score_reg <= '0;
      pending_reg    <= 1'b0;
      dropped_reg    <= 1'b0;
      top_valid_reg  <= 1'b0;
      scratch_reg    <= '0;
      top_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clear_req) begin
            wr_ptr_reg    <= '0;
            entries_reg   <= '0;
            top_reg       <= '0;
            top_valid_reg <= 1'b0;
            dropped_reg   <= 1'b0;
            pending_reg   <= 1'b0;
          end else if (pending_reg) begin
            // A fresh pulse arriving alongside the queued one takes its place in the queue.
            lat_score_reg <= pend_score_reg;
            pending_reg   <= game_over;
            if (game_over) pend_score_reg <= score;
          end else if (game_over) begin
            lat_score_reg <= score;
          end
        end
        WRITE: begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (entries_reg != FULL) entries_reg <= entries_reg + (AW+1)'(1);
          scratch_reg <= '0;
          rd_idx_reg  <= '0;
        end
        SCAN: begin
          // Read data lags the address by one cycle, so the first scan cycle has nothing to insert.
          if (rd_idx_reg != '0) scratch_reg <= scratch_ins;
          if (!scan_last) rd_idx_reg <= rd_idx_reg + AW'(1);
        end
        DRAIN:   scratch_reg <= scratch_ins;
        PUBLISH: begin
          top_reg       <= scratch_reg;
          top_valid_reg <= 1'b1;
        end
        default: ;
      endcase
      if (state_reg != IDLE && game_over) begin
        if (!pending_reg) begin
          pending_reg    <= 1'b1;
          pend_score_reg <= score;
        end else begin
          dropped_reg <= 1'b1;
        end
      end
    end
  end

  assign top0      = top_reg[0];
  assign top1      = top_reg[1];
  assign top2      = top_reg[2];
  assign top_valid = top_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign entries   = entries_reg;
  assign dropped   = dropped_reg;
endmodule

// File: tb/tb_score_log_ctrl.sv
// Randomized and directed bench for score_log_ctrl against a transaction-level score model.
module tb_score_log_ctrl;
  localparam int AW = 5;
  localparam int SW = 10;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          game_over = 1'b0;
  logic [SW-1:0] score = '0;
  logic          clr_in;
`ifdef SCORE_LOG_CLEAR_EN
  logic          clear = 1'b0;
  assign clr_in = clear;
`else
  assign clr_in = 1'b0;
`endif
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata, mem_rdata;
  logic          mem_wren;
  logic [SW-1:0] top0, top1, top2;
  logic          top_valid, busy, dropped;
  logic [AW:0]   entries;

  logic [SW-1:0] mem [DEPTH] = '{default: 10'h3FF};

  int err_cnt = 0;
  int chk_cnt = 0;
  bit chk_en = 1'b0;
  logic [31:0] scan_mask = '0;

  always #5 clock = ~clock;

  score_log_ctrl #(.AW(AW), .SW(SW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
`ifdef SCORE_LOG_CLEAR_EN
    .clear     (clear),
`endif
    .game_over (game_over),
    .score     (score),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata),
    .top0      (top0),
    .top1      (top1),
    .top2      (top2),
    .top_valid (top_valid),
    .busy      (busy),
    .entries   (entries),
    .dropped   (dropped)
  );

  // Score memory: synchronous write, registered read.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    else          mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int cyc = 0;        // posedges seen out of reset
  int idle_from = 0;  // first edge at which the controller is idle again
  int pub_edge = -1;  // edge at which the next top-3 becomes visible
  int wr_cnt = 0;
  int n_ent = 0;
  int mscores [DEPTH];
  bit m_pend = 0;
  int m_pend_score = 0;
  bit m_drop = 0;
  bit m_valid = 0;
  int m_top [3] = '{0, 0, 0};
  int p_top [3] = '{0, 0, 0};
  bit exp_wr = 0;
  int exp_waddr = 0;
  int exp_wdata = 0;
  int txn = 0;

  function automatic void calc_top();
    int q[$];
    for (int i = 0; i < n_ent; i++) q.push_back(mscores[i]);
    q.rsort();
    for (int i = 0; i < 3; i++) p_top[i] = (i < q.size()) ? q[i] : 0;
  endfunction

  task automatic model_reset();
    idle_from = cyc; pub_edge = -1; wr_cnt = 0; n_ent = 0;
    m_pend = 0; m_drop = 0; m_valid = 0; exp_wr = 0;
    for (int i = 0; i < 3; i++) m_top[i] = 0;
  endtask

  task automatic model_step();
    bit idle;
    int s;
    idle = (cyc >= idle_from);
    exp_wr = 0;
    if (cyc == pub_edge) begin
      m_top = p_top;
      m_valid = 1;
    end
    if (idle) begin
      if (clr_in) begin
        wr_cnt = 0; n_ent = 0; m_valid = 0; m_drop = 0; m_pend = 0;
        for (int i = 0; i < 3; i++) m_top[i] = 0;
        $display("txn %0d: clear", txn++);
      end else if (m_pend || game_over) begin
        if (m_pend) begin
          s = m_pend_score;
          m_pend = game_over;
          if (game_over) m_pend_score = int'(score);
        end else begin
          s = int'(score);
        end
        exp_wr = 1;
        exp_waddr = wr_cnt % DEPTH;
        exp_wdata = s;
        mscores[wr_cnt % DEPTH] = s;
        wr_cnt++;
        if (n_ent < DEPTH) n_ent++;
        calc_top();
        pub_edge = cyc + n_ent + 3;
        idle_from = cyc + n_ent + 4;
        $display("txn %0d: write addr=%0d score=%0d entries=%0d top=%0d/%0d/%0d",
                 txn++, exp_waddr, s, n_ent, p_top[0], p_top[1], p_top[2]);
      end
    end else if (game_over) begin
      if (!m_pend) begin
        m_pend = 1;
        m_pend_score = int'(score);
        $display("txn %0d: queue score=%0d", txn++, m_pend_score);
      end else begin
        m_drop = 1;
        $display("txn %0d: discard score=%0d", txn++, score);
      end
    end
    cyc++;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Cycle-exact comparison of every observable output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("wren", mem_wren, exp_wr);
      if (exp_wr) begin
        check("waddr", mem_addr, exp_waddr);
        check("wdata", mem_wdata, exp_wdata);
      end
      check("busy", busy, cyc < idle_from);
      check("top0", top0, m_top[0]);
      check("top1", top1, m_top[1]);
      check("top2", top2, m_top[2]);
      check("top_valid", top_valid, m_valid);
      check("dropped", dropped, m_drop);
      if (cyc >= idle_from) check("entries", entries, n_ent);
      if (reset_n && busy && !mem_wren) scan_mask[mem_addr] = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    game_over = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse(input int s);
    @(negedge clock);
    game_over = 1'b1;
    score = SW'(s);
    @(negedge clock);
    game_over = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 200) begin
      @(negedge clock);
      i++;
    end
    check({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    int t2_scores [5] = '{10, 300, 20, 300, 5};

    do_reset();
    chk_en = 1'b1;
    check("rst_top0", top0, 0);
    check("rst_valid", top_valid, 0);
    check("rst_entries", entries, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);

    // Single score: write to slot 0, tops published four edges later.
    pulse(50);
    check("t1_wren", mem_wren, 1);
    check("t1_waddr", mem_addr, 0);
    check("t1_wdata", mem_wdata, 50);
    wait_idle("t1");
    check("t1_top0", top0, 50);
    check("t1_top1", top1, 0);
    check("t1_top2", top2, 0);
    check("t1_valid", top_valid, 1);
    check("t1_entries", entries, 1);

    // Duplicates share the leaderboard.
    do_reset();
    foreach (t2_scores[i]) begin
      pulse(t2_scores[i]);
      wait_idle("t2");
    end
    check("t2_top0", top0, 300);
    check("t2_top1", top1, 300);
    check("t2_top2", top2, 20);
    check("t2_entries", entries, 5);

    // Wrap: slot 0 overwritten, full scan of all slots.
    do_reset();
    for (int i = 1; i <= 33; i++) begin
      if (i == 33) scan_mask = '0;
      pulse(i);
      wait_idle("t3");
    end
    check("t3_top0", top0, 33);
    check("t3_top1", top1, 32);
    check("t3_top2", top2, 31);
    check("t3_entries", entries, 32);
    check("t3_scan_mask", scan_mask, 32'hFFFF_FFFF);

    // Collisions while busy: first queued, second lost.
    do_reset();
    pulse(100);
    @(negedge clock); game_over = 1'b1; score = 10'd200;
    @(negedge clock); score = 10'd300;
    @(negedge clock); game_over = 1'b0;
    wait_idle("t4");
    @(negedge clock);
    @(negedge clock);
    wait_idle("t4b");
    check("t4_dropped", dropped, 1);
    check("t4_top0", top0, 200);
    check("t4_top1", top1, 100);
    check("t4_entries", entries, 2);

    // Reset in the middle of a scan.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(500 + i);
      wait_idle("t5");
    end
    pulse(77);
    @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("t5_top0", top0, 0);
    check("t5_valid", top_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_entries", entries, 0);
    check("t5_wren", mem_wren, 0);
    @(posedge clock); #2 reset_n = 1'b1;
    pulse(61);
    check("t5_waddr", mem_addr, 0);
    check("t5_wren2", mem_wren, 1);
    wait_idle("t5b");
    check("t5_top0b", top0, 61);
    check("t5_top1b", top1, 0);

`ifdef SCORE_LOG_CLEAR_EN
    // Clear beats a simultaneous game_over.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(40 + i);
      wait_idle("t6");
    end
    @(negedge clock); clear = 1'b1; game_over = 1'b1; score = 10'd999;
    @(negedge clock); clear = 1'b0; game_over = 1'b0;
    check("t6_wren", mem_wren, 0);
    check("t6_entries", entries, 0);
    check("t6_valid", top_valid, 0);
    check("t6_dropped", dropped, 0);
    check("t6_busy", busy, 0);
`endif

    // Random traffic, including bursts while busy and duplicate-heavy scores.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      game_over = ($urandom_range(0, 5) == 0);
      score = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(0, 1023)) : SW'($urandom_range(0, 7));
`ifdef SCORE_LOG_CLEAR_EN
      clear = ($urandom_range(0, 60) == 0);
`endif
    end
    @(negedge clock);
    game_over = 1'b0;
`ifdef SCORE_LOG_CLEAR_EN
    clear = 1'b0;
`endif
    wait_idle("rnd");
    repeat (2) @(negedge clock);
    wait_idle("rnd_b");
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
